// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

  // Which requester owns the transfer / the pending response.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_e;

  // Simulation-control addresses; they pass through the arbiter untouched.
  localparam int unsigned SIM_PUTC_ADDR  = 'h40;
  localparam int unsigned SIM_HALT_ADDR  = 'h50;
  localparam int unsigned SIM_CYCLE_ADDR = 'h60;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: R1 has priority unless R0 is being forced.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       force_r0,
  output owner_e     owner
);

  // req[0] = R0 (fetch), req[1] = R1 (LSU)
  always_comb begin
    owner = OWN_NONE;
    case (req)
      2'b01:   owner = OWN_R0;
      2'b10:   owner = OWN_R1;
      2'b11:   owner = force_r0 ? OWN_R0 : OWN_R1;
      default: owner = OWN_NONE;
    endcase
  end

endmodule

// File: rtl/mem_sp_arbiter.sv
// Two-requester arbiter in front of a single-port, 1-cycle-latency memory.
module mem_sp_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = DATA_WIDTH,
  parameter int unsigned DATA_BYTES   = DATA_WIDTH / 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_r0_req,
  input  logic [ADDR_WIDTH-1:0] i_r0_addr,
  input  logic [DATA_WIDTH-1:0] i_r0_wdata,
  input  logic [DATA_BYTES-1:0] i_r0_wen,
  output logic                  o_r0_gnt,
  output logic                  o_r0_rvalid,
  output logic [DATA_WIDTH-1:0] o_r0_rdata,
  input  logic                  i_r1_req,
  input  logic [ADDR_WIDTH-1:0] i_r1_addr,
  input  logic [DATA_WIDTH-1:0] i_r1_wdata,
  input  logic [DATA_BYTES-1:0] i_r1_wen,
  output logic                  o_r1_gnt,
  output logic                  o_r1_rvalid,
  output logic [DATA_WIDTH-1:0] o_r1_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [DATA_BYTES-1:0] o_mem_wen,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  owner_e        resp_q, resp_d;
  owner_e        pick_owner;
  owner_e        owner;
  logic          force_r0;

  assign force_r0 = (starve_q == SW'(STARVE_LIMIT));

  mem_arb_pick u_pick (
    .req      ({i_r1_req, i_r0_req}),
    .force_r0 (force_r0),
    .owner    (pick_owner)
  );

  // Grants are suppressed entirely while reset is held.
  always_comb begin
    owner    = rst ? OWN_NONE : pick_owner;
    o_r0_gnt = (owner == OWN_R0);
    o_r1_gnt = (owner == OWN_R1);
  end

  // Memory side driven from the winner; all zero when idle so address 0x60 is never hit.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wen   = '0;
    case (owner)
      OWN_R0: begin
        o_mem_addr  = i_r0_addr;
        o_mem_wdata = i_r0_wdata;
        o_mem_wen   = i_r0_wen;
      end
      OWN_R1: begin
        o_mem_addr  = i_r1_addr;
        o_mem_wdata = i_r1_wdata;
        o_mem_wen   = i_r1_wen;
      end
      default: begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wen   = '0;
      end
    endcase
  end

  // Starvation counter and response owner next-state.
  always_comb begin
    starve_d = '0;
    resp_d   = owner;
    if (i_r0_req && !o_r0_gnt) begin
      starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    end
  end

  // Response steering; rst also kills a response that is in flight.
  always_comb begin
    o_r0_rvalid = !rst && (resp_q == OWN_R0);
    o_r1_rvalid = !rst && (resp_q == OWN_R1);
    o_r0_rdata  = o_r0_rvalid ? i_mem_rdata : '0;
    o_r1_rdata  = o_r1_rvalid ? i_mem_rdata : '0;
  end

  // State registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      resp_q   <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      resp_q   <= resp_d;
    end
  end

endmodule
